// File: rtl/gate_vector_checker.sv
// Stimulus/check stage for a 2-input gate: walks {a,b} through 00..11, samples gate_out after a settle time,
// and compares against TRUTH. Optional macro STOP_ON_FAIL_EN ends the run at the first mismatch.
module gate_vector_checker #(
    parameter logic [3:0]  TRUTH  = 4'b0111,
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       gate_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] pass_cnt,
    output logic [2:0] fail_cnt,
    output logic [1:0] fail_idx
);

    // state  | meaning
    // IDLE   | waiting for start after reset
    // DRIVE  | {a,b} just driven with idx
    // SETTLE | settle_cnt counts down to terminal count 0
    // CHECK  | sample gate_out, update counts, advance or finish
    // DONE   | results held until start or rst
    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LD = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

    state_t     state;
    logic [1:0] idx;
    logic [3:0] settle_cnt;
    logic       match;
    logic       stop_run;
    logic [2:0] pass_cnt_nxt;
    logic [2:0] fail_cnt_nxt;

    // Case-equality so an X/Z on gate_out never counts as a match.
    assign match        = (gate_out === TRUTH[idx]);
    assign pass_cnt_nxt = pass_cnt + {2'b00, match};
    assign fail_cnt_nxt = fail_cnt + {2'b00, ~match};

`ifdef STOP_ON_FAIL_EN
    assign stop_run = (idx == 2'd3) || !match;
`else
    assign stop_run = (idx == 2'd3);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= 2'd0;
            settle_cnt <= 4'd0;
            a          <= 1'b0;
            b          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            pass_cnt   <= 3'd0;
            fail_cnt   <= 3'd0;
            fail_idx   <= 2'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state    <= S_DRIVE;
                        idx      <= 2'd0;
                        a        <= 1'b0;
                        b        <= 1'b0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        pass     <= 1'b0;
                        pass_cnt <= 3'd0;
                        fail_cnt <= 3'd0;
                        fail_idx <= 2'd0;
                    end
                end
                S_DRIVE: begin
                    if (SETTLE == 0) begin
                        state <= S_CHECK;
                    end else begin
                        state      <= S_SETTLE;
                        settle_cnt <= SETTLE_LD;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        state <= S_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                S_CHECK: begin
                    pass_cnt <= pass_cnt_nxt;
                    fail_cnt <= fail_cnt_nxt;
                    if (!match && (fail_cnt == 3'd0)) begin
                        fail_idx <= idx;
                    end
                    if (stop_run) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (fail_cnt_nxt == 3'd0);
                    end else begin
                        state  <= S_DRIVE;
                        idx    <= idx + 2'd1;
                        {a, b} <= idx + 2'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench for gate_vector_checker: default NAND instance with selectable gate models,
// plus an AND instance with SETTLE=0.
module tb_gate_vector_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       a, b, gate_out, busy, done, pass;
    logic [2:0] pass_cnt, fail_cnt;
    logic [1:0] fail_idx;

    logic       start6;
    logic       a6, b6, gate_out6, busy6, done6, pass6;
    logic [2:0] pass_cnt6, fail_cnt6;
    logic [1:0] fail_idx6;

    int mode;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // 0 = NAND, 1 = stuck at 1, 2 = stuck at 0
    always_comb begin
        case (mode)
            1:       gate_out = 1'b1;
            2:       gate_out = 1'b0;
            default: gate_out = ~(a & b);
        endcase
    end

    assign gate_out6 = a6 & b6;

    gate_vector_checker dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .gate_out(gate_out),
        .busy(busy), .done(done), .pass(pass), .pass_cnt(pass_cnt),
        .fail_cnt(fail_cnt), .fail_idx(fail_idx)
    );

    gate_vector_checker #(.TRUTH(4'b1000), .SETTLE(0)) dut6 (
        .clk(clk), .rst(rst), .start(start6), .a(a6), .b(b6), .gate_out(gate_out6),
        .busy(busy6), .done(done6), .pass(pass6), .pass_cnt(pass_cnt6),
        .fail_cnt(fail_cnt6), .fail_idx(fail_idx6)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Count edges after the start edge until done; optionally pulse start at edge pulse_at.
    task automatic wait_done(input int pulse_at, output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            start = (i == pulse_at);
            tick();
            start = 1'b0;
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic chk_results(input string tag, input int p, input int pc, input int fc, input int fi);
        chk({tag, "_pass"}, pass, p);
        chk({tag, "_pass_cnt"}, pass_cnt, pc);
        chk({tag, "_fail_cnt"}, fail_cnt, fc);
        chk({tag, "_fail_idx"}, fail_idx, fi);
    endtask

    initial begin
        int lat;
        logic [1:0] seq [4];

        mode   = 0;
        start  = 1'b0;
        start6 = 1'b0;
        rst    = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ab", {a, b}, 0);
        chk_results("rst", 0, 0, 0, 0);

        // T1: NAND model, SETTLE=2
        do_start();
        chk("t1_busy", busy, 1);
        chk("t1_done_early", done, 0);
        wait_done(0, lat);
        chk("t1_latency", lat, 16);
        chk_results("t1", 1, 4, 0, 0);
        chk("t1_ab_hold", {a, b}, 3);
        chk("t1_busy_off", busy, 0);
        tick();
        chk("t1_done_sticky", done, 1);

        // T2: stuck at 1 -> only idx 3 fails
        mode = 1;
        do_start();
        chk("t2_cleared", pass_cnt, 0);
        wait_done(0, lat);
        chk("t2_latency", lat, 16);
        chk_results("t2", 0, 3, 1, 3);

        // T3: stuck at 0 -> idx 0..2 fail
        mode = 2;
        do_start();
        wait_done(0, lat);
`ifdef STOP_ON_FAIL_EN
        chk("t3_latency", lat, 4);
        chk_results("t3", 0, 0, 1, 0);
`else
        chk("t3_latency", lat, 16);
        chk_results("t3", 0, 1, 3, 0);
`endif

        // T4: start pulsed while busy is ignored
        mode = 0;
        do_start();
        wait_done(5, lat);
        chk("t4_latency", lat, 16);
        chk_results("t4", 1, 4, 0, 0);

        // T5: reset mid-run at k+7, then a clean run
        mode = 1;
        do_start();
        for (int i = 1; i <= 6; i++) tick();
        chk("t5_busy_pre", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_ab", {a, b}, 0);
        chk_results("t5_rst", 0, 0, 0, 0);
        tick();
        chk("t5_idle_hold", busy, 0);
        mode = 0;
        do_start();
        wait_done(0, lat);
        chk("t5_latency", lat, 16);
        chk_results("t5", 1, 4, 0, 0);

        // T6: AND instance, SETTLE=0
        start6 = 1'b1;
        tick();
        start6 = 1'b0;
        seq[0] = {a6, b6};
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 2) seq[1] = {a6, b6};
            if (i == 4) seq[2] = {a6, b6};
            if (i == 6) seq[3] = {a6, b6};
            if (done6 === 1'b1) begin
                lat = i;
                break;
            end
        end
        chk("t6_latency", lat, 8);
        for (int v = 0; v < 4; v++) chk($sformatf("t6_ab%0d", v), seq[v], v);
        chk("t6_pass", pass6, 1);
        chk("t6_pass_cnt", pass_cnt6, 4);
        chk("t6_fail_cnt", fail_cnt6, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
